instr_mem_responder: RTL and testbench

Instruction-memory responder at the far end of the program-counter address bus. It samples the fetch address driven by the PC register, performs a word read from an internal instruction RAM after a parameterised number of wait states, and returns the instruction. While the access is in flight it asserts `pc_hold` back to the PC register, so the PC advances exactly once per delivered instruction. A write-only load port fills the RAM before or between runs.

---
 rtl/instr_mem_responder_if.sv | 32 +++
 rtl/instr_mem_responder.sv | 139 +++++++++++++
 tb/tb_instr_mem_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder_if
// Description : Bus bundle between the program-counter side (master) and the
//               instruction-memory responder (slave).
//               master drives : address_bus_IR, load_en, load_addr, load_data
//               slave drives  : instr_out, instr_valid, pc_hold, fetch_fault
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]       address_bus_IR;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic [31:0]       instr_out;
  logic              instr_valid;
  logic              pc_hold;
  logic              fetch_fault;

  modport master (
    output address_bus_IR, load_en, load_addr, load_data,
    input  instr_out, instr_valid, pc_hold, fetch_fault
  );

  modport slave (
    input  address_bus_IR, load_en, load_addr, load_data,
    output instr_out, instr_valid, pc_hold, fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder
// Description : Instruction-memory responder. Samples the PC fetch address in
//               IDLE, waits WAIT_STATES cycles, then returns one instruction
//               word (or NOP_INSTR with fetch_fault on a misaligned /
//               out-of-range address). pc_hold is low only in the response
//               cycle so the PC advances once per delivered instruction.
//               A write-only load port fills the RAM while IDLE.
// Ports       : clock  - rising-edge clock
//               reset  - synchronous, active-low
//               bus    - instr_mem_responder_if.slave
//                        (address_bus_IR, load_en/addr/data in;
//                         instr_out, instr_valid, pc_hold, fetch_fault out)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  wire logic             clock,
  input  wire logic             reset,
  instr_mem_responder_if.slave  bus
);

  localparam logic [3:0] c_wait_states = 4'(WAIT_STATES);
  localparam int         c_depth       = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_cnt_nxt;
  logic [31:0]       r_addr_q;
  logic [31:0]       w_addr_nxt;
  logic [31:0]       r_instr;
  logic              r_fault;
  logic              w_mem_we;
  logic              w_resp_load;

  logic [31:0]       w_rd_addr;
  logic [ADDR_W-1:0] w_word_idx;
  logic              w_misaligned;
  logic              w_out_of_range;

  logic [31:0]       r_mem [0:c_depth-1];

  // With zero wait states the data is captured on the same edge that samples
  // the address, so the decode must look at the live bus while in IDLE.
  // In every other case it looks at the latched address.
  assign w_rd_addr      = (r_state == ST_IDLE) ? bus.address_bus_IR : r_addr_q;
  assign w_word_idx     = w_rd_addr[ADDR_W+1:2];
  assign w_misaligned   = |w_rd_addr[1:0];
  assign w_out_of_range = |w_rd_addr[31:ADDR_W+2];

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_addr_nxt     = r_addr_q;
    w_mem_we       = 1'b0;
    w_resp_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_en) begin
          // Loader has priority: write and keep stalling the fetch.
          w_mem_we = 1'b1;
        end else begin
          w_addr_nxt     = bus.address_bus_IR;
          w_wait_cnt_nxt = c_wait_states;
          if (c_wait_states == 4'd0) begin
            w_state_nxt = ST_RESP;
            w_resp_load = 1'b1;
          end else begin
            w_state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        // "<= 1" rather than "== 1" so a corrupted zero count cannot wrap
        // into a 15-cycle stall.
        if (r_wait_cnt <= 4'd1) begin
          w_state_nxt = ST_RESP;
          w_resp_load = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr_q   <= 32'd0;
      r_instr    <= NOP_INSTR;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_addr_q   <= w_addr_nxt;
      if (w_resp_load) begin
        if (w_misaligned || w_out_of_range) begin
          r_instr <= NOP_INSTR;
          r_fault <= 1'b1;
        end else begin
          r_instr <= r_mem[w_word_idx];
          r_fault <= 1'b0;
        end
      end
    end
  end

  // RAM contents are deliberately not reset so a loaded program survives
  // a reset of the fetch logic.
  always_ff @(posedge clock) begin
    if (w_mem_we && reset) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.instr_out   = r_instr;
  assign bus.fetch_fault = r_fault;
  assign bus.instr_valid = (r_state == ST_RESP);
  assign bus.pc_hold     = (r_state != ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_responder
// Description : Self-checking bench. Two responders (WAIT_STATES=2 and 0)
//               share one clock; the bench plays the PC register and the
//               loader, and predicts every response from a word-array model
//               of the RAM plus the fetch-period rule (IDLE, WAIT_STATES
//               ACCESS cycles, one RESP cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;

  localparam int          AW  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mdl [2][256];

  always #5 clk = ~clk;

  instr_mem_responder_if #(.ADDR_W(AW)) ifa ();
  instr_mem_responder_if #(.ADDR_W(AW)) ifb ();

  instr_mem_responder #(.ADDR_W(AW), .WAIT_STATES(2), .NOP_INSTR(NOP)) dut_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  instr_mem_responder #(.ADDR_W(AW), .WAIT_STATES(0), .NOP_INSTR(NOP)) dut_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  function automatic int ws(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  // {fault, instruction} expected for a fetch of byte address a.
  function automatic logic [32:0] expect_of(input int sel, input logic [31:0] a);
    logic [AW-1:0] idx;
    if (a[1:0] != 2'b00 || a[31:AW+2] != '0) return {1'b1, NOP};
    idx = a[AW+1:2];
    return {1'b0, mdl[sel][idx]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [31:0] a, input logic le,
                       input logic [AW-1:0] la, input logic [31:0] ld);
    if (sel == 0) begin
      ifa.address_bus_IR = a; ifa.load_en = le; ifa.load_addr = la; ifa.load_data = ld;
    end else begin
      ifb.address_bus_IR = a; ifb.load_en = le; ifb.load_addr = la; ifb.load_data = ld;
    end
  endtask

  task automatic obs(input int sel, output logic [31:0] ins, output logic v,
                     output logic h, output logic f);
    if (sel == 0) begin
      ins = ifa.instr_out; v = ifa.instr_valid; h = ifa.pc_hold; f = ifa.fetch_fault;
    end else begin
      ins = ifb.instr_out; v = ifb.instr_valid; h = ifb.pc_hold; f = ifb.fetch_fault;
    end
  endtask

  // Holds both DUTs in reset for n edges, checking the selected one, then
  // releases only the selected DUT ahead of the next edge.
  task automatic do_reset(input int sel, input int n);
    logic [31:0] ins; logic v, h, f;
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 32'd0, 1'b0, '0, 32'd0);
    drive(1, 32'd0, 1'b0, '0, 32'd0);
    for (int i = 0; i < n; i++) begin
      step();
      obs(sel, ins, v, h, f);
      chk("rst_instr", ins, NOP);
      chk("rst_valid", 32'(v), 32'd0);
      chk("rst_hold",  32'(h), 32'd1);
      chk("rst_fault", 32'(f), 32'd0);
    end
    if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
  endtask

  // Loader write held for ncyc cycles in IDLE; the address bus is scrambled
  // to show it is not sampled. load_en is left high on exit.
  task automatic load_word(input int sel, input logic [AW-1:0] idx,
                           input logic [31:0] data, input int ncyc);
    logic [31:0] ins; logic v, h, f;
    for (int i = 0; i < ncyc; i++) begin
      drive(sel, $urandom, 1'b1, idx, data);
      step();
      obs(sel, ins, v, h, f);
      chk("load_valid", 32'(v), 32'd0);
      chk("load_hold",  32'(h), 32'd1);
    end
    mdl[sel][idx] = data;
  endtask

  // One complete fetch starting from an IDLE cycle. With churn set, the
  // address bus and the load port are scrambled after the sampling edge.
  task automatic fetch_one(input int sel, input logic [31:0] a, input bit churn);
    logic [31:0] ins; logic v, h, f; logic [32:0] e;
    e = expect_of(sel, a);
    drive(sel, a, 1'b0, '0, 32'd0);
    step();
    for (int k = 0; k < ws(sel); k++) begin
      obs(sel, ins, v, h, f);
      chk("acc_valid", 32'(v), 32'd0);
      chk("acc_hold",  32'(h), 32'd1);
      if (churn) drive(sel, $urandom, 1'b1, AW'($urandom), $urandom);
      else       drive(sel, a, 1'b0, '0, 32'd0);
      step();
    end
    obs(sel, ins, v, h, f);
    chk("resp_valid", 32'(v), 32'd1);
    chk("resp_hold",  32'(h), 32'd0);
    chk("resp_instr", ins, e[31:0]);
    chk("resp_fault", 32'(f), 32'(e[32]));
    drive(sel, churn ? $urandom : a, 1'b0, '0, 32'd0);
    step();
    obs(sel, ins, v, h, f);
    chk("idle_valid", 32'(v), 32'd0);
    chk("idle_hold",  32'(h), 32'd1);
    chk("hold_instr", ins, e[31:0]);
    chk("hold_fault", 32'(f), 32'(e[32]));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] ins; logic v, h, f;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 32'd0, 1'b0, '0, 32'd0);
    drive(1, 32'd0, 1'b0, '0, 32'd0);

    // ---- DUT A (WAIT_STATES=2) ----
    do_reset(0, 3);
    for (int i = 0; i < 64; i++)
      load_word(0, AW'(i), (i < 4) ? (32'hA000_0000 + 32'(i)) : $urandom, 1);
    for (int i = 0; i < 4; i++) fetch_one(0, 32'(4 * i), 1'b0);
    fetch_one(0, 32'h0000_0006, 1'b0);
    fetch_one(0, 32'h0000_0400, 1'b0);
    fetch_one(0, 32'h0000_0010, 1'b0);

    // Reset while in ACCESS aborts the fetch; instr_out returns to NOP.
    drive(0, 32'h0000_0004, 1'b0, '0, 32'd0);
    step();
    step();
    obs(0, ins, v, h, f);
    chk("pre_rst_valid", 32'(v), 32'd0);
    do_reset(0, 3);
    fetch_one(0, 32'h0000_0004, 1'b0);

    // Loader priority and write-before-fetch visibility.
    load_word(0, AW'(2), 32'hDEAD_BEEF, 5);
    fetch_one(0, 32'h0000_0008, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      fetch_one(0, a, 1'b1);
    end

    // ---- DUT B (WAIT_STATES=0); DUT A sits in reset ----
    do_reset(1, 2);
    for (int i = 0; i < 4; i++) load_word(1, AW'(i), 32'hA000_0000 + 32'(i), 1);
    for (int i = 0; i < 4; i++) fetch_one(1, 32'(4 * i), 1'b0);
    fetch_one(1, 32'h0000_0006, 1'b0);
    do_reset(1, 1);
    for (int i = 0; i < 10; i++) begin
      a = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      fetch_one(1, a, 1'b1);
    end

    // ---- DUT A again: RAM survived the reset ----
    do_reset(0, 1);
    fetch_one(0, 32'h0000_0008, 1'b0);
    fetch_one(0, 32'h0000_000C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
